// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmem_state_t : responder FSM state encoding (IDLE, READ, WRITE, ERROR)
//   - DMEM_BASE_ADDR : default byte address of RAM word 0
//   - DMEM_CNT_W     : width of the optional statistics counters
//   - sat_inc()      : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_ERROR = 2'd3
   } dmem_state_t;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
   localparam int          DMEM_CNT_W     = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [DMEM_CNT_W-1:0] sat_inc(input logic [DMEM_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Core data-port bus between the RISC-V core (master) and the memory
// responder (slave).
//   MemRead    : load strobe, level, master -> slave
//   MemWrite   : store strobe, level, master -> slave
//   dAddress   : 32-bit byte address, master -> slave
//   dWriteData : 32-bit store data, master -> slave
//   dReadData  : 32-bit registered load data, slave -> master
// ---------------------------------------------------------------------------
interface dmem_responder_if;

   logic        MemRead;
   logic        MemWrite;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;

   modport master (
      output MemRead, MemWrite, dAddress, dWriteData,
      input  dReadData
   );

   modport slave (
      input  MemRead, MemWrite, dAddress, dWriteData,
      output dReadData
   );

endinterface

// File: rtl/dmem_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous word RAM, DEPTH_WORDS x 32 bits. The array is kept
// in this module alone so it can be replaced by a technology macro.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears rdata only, never the array)
//   re    : read enable, loads rdata with mem[addr]
//   we    : write enable, mem[addr] <= wdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, held between reads
// ---------------------------------------------------------------------------
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          re,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Array has no reset so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the multicycle RISC-V core's data port. Detects
// rising MemRead/MemWrite strobes, decodes the byte address against
// BASE_ADDR, and services one word access per strobe from an internal RAM.
// Bad accesses (out of range, misaligned, read+write together) are rejected
// and reported.
//
// Optional feature: define DMEM_STATS_EN to add saturating access counters.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : dmem_responder_if.slave (MemRead, MemWrite, dAddress,
//                dWriteData in; dReadData out)
//   busy       : high while the FSM is not in IDLE
//   access_err : one-cycle pulse during the ERROR state
//   err_sticky : set by any rejected access, cleared only by reset
//   err_addr   : dAddress of the most recent rejected access
//   rd_count / wr_count / err_count (DMEM_STATS_EN only) : completed
//                READ / WRITE / ERROR states, saturating
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dmem_responder_if.slave       bus,
   output logic                  busy,
   output logic                  access_err,
   output logic                  err_sticky,
   output logic [31:0]           err_addr
`ifdef DMEM_STATS_EN
   ,
   output logic [DMEM_CNT_W-1:0] rd_count,
   output logic [DMEM_CNT_W-1:0] wr_count,
   output logic [DMEM_CNT_W-1:0] err_count
`endif
);

   localparam int         IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   dmem_state_t state_reg;
   logic        rd_q_reg;
   logic        wr_q_reg;
   logic        busy_reg;
   logic        access_err_reg;
   logic        err_sticky_reg;
   logic [31:0] err_addr_reg;

   logic             new_rd;
   logic             new_wr;
   logic             in_idle;
   logic [31:0]      off;
   logic             addr_ok;
   logic [IDX_W-1:0] idx;
   logic             start_rd;
   logic             start_wr;
   logic             start_err;
   logic             ram_we;
   logic [31:0]      ram_rdata;

   // Edge detect on the level strobes: a strobe held N cycles is one access.
   assign new_rd  = bus.MemRead  & ~rd_q_reg;
   assign new_wr  = bus.MemWrite & ~wr_q_reg;
   assign in_idle = (state_reg == ST_IDLE);

   // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
   assign off     = bus.dAddress - BASE_ADDR;
   assign addr_ok = ({1'b0, off} < SPAN_BYTES) && (bus.dAddress[1:0] == 2'b00);
   assign idx     = off[IDX_W+1:2];

   assign start_rd  = in_idle & new_rd & ~new_wr & addr_ok;
   assign start_wr  = in_idle & new_wr & ~new_rd & addr_ok;
   assign start_err = in_idle & (new_rd | new_wr) & ((new_rd & new_wr) | ~addr_ok);

   // The array has no reset of its own, so block writes while reset is held.
   assign ram_we = start_wr & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         rd_q_reg       <= 1'b0;
         wr_q_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         access_err_reg <= 1'b0;
         err_sticky_reg <= 1'b0;
         err_addr_reg   <= '0;
      end else begin
         // Strobe history updates in every state so dropped rises never replay.
         rd_q_reg       <= bus.MemRead;
         wr_q_reg       <= bus.MemWrite;
         busy_reg       <= 1'b0;
         access_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_err) begin
                  state_reg      <= ST_ERROR;
                  busy_reg       <= 1'b1;
                  access_err_reg <= 1'b1;
                  err_sticky_reg <= 1'b1;
                  err_addr_reg   <= bus.dAddress;
               end else if (start_rd) begin
                  state_reg <= ST_READ;
                  busy_reg  <= 1'b1;
               end else if (start_wr) begin
                  state_reg <= ST_WRITE;
                  busy_reg  <= 1'b1;
               end
            end
            default: begin
               // READ, WRITE and ERROR are single-cycle service states.
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .re    (start_rd),
      .we    (ram_we),
      .addr  (idx),
      .wdata (bus.dWriteData),
      .rdata (ram_rdata)
   );

   assign bus.dReadData = ram_rdata;
   assign busy          = busy_reg;
   assign access_err    = access_err_reg;
   assign err_sticky    = err_sticky_reg;
   assign err_addr      = err_addr_reg;

`ifdef DMEM_STATS_EN
   logic [DMEM_CNT_W-1:0] rd_cnt_reg;
   logic [DMEM_CNT_W-1:0] wr_cnt_reg;
   logic [DMEM_CNT_W-1:0] err_cnt_reg;

   // A service state counts as completed on the edge that leaves it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_reg  <= '0;
         wr_cnt_reg  <= '0;
         err_cnt_reg <= '0;
      end else begin
         if (state_reg == ST_READ) begin
            rd_cnt_reg <= sat_inc(rd_cnt_reg);
         end
         if (state_reg == ST_WRITE) begin
            wr_cnt_reg <= sat_inc(wr_cnt_reg);
         end
         if (state_reg == ST_ERROR) begin
            err_cnt_reg <= sat_inc(err_cnt_reg);
         end
      end
   end

   assign rd_count  = rd_cnt_reg;
   assign wr_count  = wr_cnt_reg;
   assign err_count = err_cnt_reg;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A behavioural model (word array,
// last-read value, error registers) predicts every observable output.
// Covers DMEM_STATS_EN counters when that macro is defined.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   logic        busy;
   logic        access_err;
   logic        err_sticky;
   logic [31:0] err_addr;
`ifdef DMEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic [15:0] err_count;
`endif

   dmem_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .access_err (access_err),
      .err_sticky (err_sticky),
      .err_addr   (err_addr)
`ifdef DMEM_STATS_EN
      ,
      .rd_count   (rd_count),
      .wr_count   (wr_count),
      .err_count  (err_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_rd;
   logic        exp_sticky;
   logic [31:0] exp_err_addr;

   function automatic bit addr_valid(input logic [31:0] a);
      longint unsigned la;
      longint unsigned lo;
      la = longint'(a);
      lo = longint'(BASE);
      return (la >= lo) && (la < lo + 4 * DEPTH) && ((la % 4) == 0);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   // Predict the effect of one access; err reports whether it is rejected.
   task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, output bit err);
      err = (rd && wr) || !addr_valid(a);
      if (err) begin
         exp_sticky   = 1'b1;
         exp_err_addr = a;
      end else if (rd) begin
         exp_rd = mem_m[word_of(a)];
      end else if (wr) begin
         mem_m[word_of(a)] = d;
      end
   endtask

   task automatic model_reset();
      exp_rd       = '0;
      exp_sticky   = 1'b0;
      exp_err_addr = '0;
   endtask

   // Raise strobes at a negedge and return at the negedge after the sampling edge.
   task automatic start_access(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d);
      @(negedge clk);
      bus.MemRead    = rd;
      bus.MemWrite   = wr;
      bus.dAddress   = a;
      bus.dWriteData = d;
      @(negedge clk);
   endtask

   task automatic end_access();
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.dAddress   = '0;
      bus.dWriteData = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.dReadData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.dReadData); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++;
      if (access_err !== 1'b0) begin n_fail++; $display("FAIL reset_access_err got=%b exp=0", access_err); end
      n_checks++;
      if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
      n_checks++;
      if (err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
      $display("reset: dReadData=%h busy=%b err_sticky=%b", bus.dReadData, busy, err_sticky);
   endtask

   task automatic test_store_load();
      bit err;
      int busy_cycles = 0;
      bit err_seen = 1'b0;
      model_access(1'b0, 1'b1, 32'h1001_0004, 32'hCAFE_F00D, err);
      start_access(1'b0, 1'b1, 32'h1001_0004, 32'hCAFE_F00D);
      busy_cycles += int'(busy); err_seen |= access_err;
      @(negedge clk);
      busy_cycles += int'(busy); err_seen |= access_err;
      end_access();
      busy_cycles += int'(busy); err_seen |= access_err;
      n_checks++;
      if (busy_cycles != 1) begin n_fail++; $display("FAIL store_one_write busy_cycles=%0d exp=1", busy_cycles); end
      model_access(1'b1, 1'b0, 32'h1001_0004, 32'h0, err);
      start_access(1'b1, 1'b0, 32'h1001_0004, 32'h0);
      err_seen |= access_err;
      n_checks++;
      if (bus.dReadData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL load_data got=%h exp=cafef00d", bus.dReadData); end
      end_access();
      err_seen |= access_err;
      n_checks++;
      if (err_seen !== 1'b0) begin n_fail++; $display("FAIL store_load_no_err got=%b exp=0", err_seen); end
      $display("store_load: addr=10010004 rdata=%h busy_cycles=%0d", bus.dReadData, busy_cycles);
   endtask

   task automatic test_misaligned();
      bit err;
      logic [31:0] prev = exp_rd;
      model_access(1'b1, 1'b0, 32'h1001_0002, 32'h0, err);
      start_access(1'b1, 1'b0, 32'h1001_0002, 32'h0);
      n_checks++;
      if (access_err !== 1'b1) begin n_fail++; $display("FAIL misaligned_err got=%b exp=1", access_err); end
      n_checks++;
      if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL misaligned_sticky got=%b exp=1", err_sticky); end
      n_checks++;
      if (err_addr !== 32'h1001_0002) begin n_fail++; $display("FAIL misaligned_err_addr got=%h exp=10010002", err_addr); end
      n_checks++;
      if (bus.dReadData !== prev) begin n_fail++; $display("FAIL misaligned_rdata got=%h exp=%h", bus.dReadData, prev); end
      @(negedge clk);
      n_checks++;
      if (access_err !== 1'b0) begin n_fail++; $display("FAIL misaligned_pulse_width got=%b exp=0", access_err); end
      n_checks++;
      if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL misaligned_sticky_hold got=%b exp=1", err_sticky); end
      end_access();
      $display("misaligned: addr=10010002 err_addr=%h sticky=%b", err_addr, err_sticky);
   endtask

   task automatic test_range_edges();
      bit err;
      logic [31:0] top = BASE + 32'(4 * DEPTH - 4);
      logic [31:0] past = BASE + 32'(4 * DEPTH);
      model_access(1'b0, 1'b1, top, 32'h7E57_0001, err);
      start_access(1'b0, 1'b1, top, 32'h7E57_0001);
      n_checks++;
      if (access_err !== err) begin n_fail++; $display("FAIL top_word_write err got=%b exp=%b", access_err, err); end
      end_access();
      model_access(1'b1, 1'b0, top, 32'h0, err);
      start_access(1'b1, 1'b0, top, 32'h0);
      n_checks++;
      if (bus.dReadData !== 32'h7E57_0001) begin n_fail++; $display("FAIL top_word_read got=%h exp=7e570001", bus.dReadData); end
      end_access();
      model_access(1'b0, 1'b1, past, 32'h1, err);
      start_access(1'b0, 1'b1, past, 32'h1);
      n_checks++;
      if (access_err !== 1'b1 || err_addr !== past) begin
         n_fail++; $display("FAIL past_end err=%b err_addr=%h exp err=1 err_addr=%h", access_err, err_addr, past);
      end
      end_access();
      model_access(1'b0, 1'b1, 32'h1000_FFFC, 32'h2, err);
      start_access(1'b0, 1'b1, 32'h1000_FFFC, 32'h2);
      n_checks++;
      if (access_err !== 1'b1 || err_addr !== 32'h1000_FFFC) begin
         n_fail++; $display("FAIL below_base err=%b err_addr=%h exp err=1 err_addr=1000fffc", access_err, err_addr);
      end
      end_access();
      $display("range_edges: top=%h past=%h below=1000fffc", top, past);
   endtask

   task automatic test_simultaneous();
      bit err;
      logic [31:0] a = BASE + 32'd20;
      model_access(1'b0, 1'b1, a, 32'h1111_2222, err);
      start_access(1'b0, 1'b1, a, 32'h1111_2222);
      end_access();
      model_access(1'b1, 1'b1, a, 32'hDEAD_BEEF, err);
      start_access(1'b1, 1'b1, a, 32'hDEAD_BEEF);
      n_checks++;
      if (access_err !== 1'b1) begin n_fail++; $display("FAIL simul_err got=%b exp=1", access_err); end
      n_checks++;
      if (bus.dReadData !== exp_rd) begin n_fail++; $display("FAIL simul_rdata got=%h exp=%h", bus.dReadData, exp_rd); end
      end_access();
      model_access(1'b1, 1'b0, a, 32'h0, err);
      start_access(1'b1, 1'b0, a, 32'h0);
      n_checks++;
      if (bus.dReadData !== 32'h1111_2222) begin n_fail++; $display("FAIL simul_mem_kept got=%h exp=11112222", bus.dReadData); end
      end_access();
      $display("simultaneous: addr=%h readback=%h", a, bus.dReadData);
   endtask

   task automatic test_random();
      bit err;
      bit rd;
      bit wr;
      logic [31:0] a;
      logic [31:0] d;
      int kind;
      int hold;
      // Fill a pool of words so random reads always have defined data.
      for (int i = 0; i < 32; i++) begin
         a = BASE + 32'(4 * i);
         d = $urandom;
         model_access(1'b0, 1'b1, a, d, err);
         start_access(1'b0, 1'b1, a, d);
         end_access();
      end
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 4);
         a    = BASE + 32'(4 * $urandom_range(0, 31));
         d    = $urandom;
         rd   = 1'b0;
         wr   = 1'b0;
         case (kind)
            0: rd = 1'b1;
            1: wr = 1'b1;
            2: begin rd = ($urandom_range(0, 1) == 1); wr = !rd; a = a + 32'($urandom_range(1, 3)); end
            3: begin
               rd = ($urandom_range(0, 1) == 1); wr = !rd;
               if ($urandom_range(0, 1) == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
               else                           a = BASE - 32'(4 * $urandom_range(1, 1000));
            end
            default: begin rd = 1'b1; wr = 1'b1; end
         endcase
         hold = $urandom_range(1, 3);
         model_access(rd, wr, a, d, err);
         start_access(rd, wr, a, d);
         n_checks++;
         if (busy !== 1'b1 || access_err !== err || err_sticky !== exp_sticky ||
             err_addr !== exp_err_addr || bus.dReadData !== exp_rd) begin
            n_fail++;
            $display("FAIL random_op%0d busy=%b err=%b sticky=%b err_addr=%h rdata=%h exp busy=1 err=%b sticky=%b err_addr=%h rdata=%h",
                     n, busy, access_err, err_sticky, err_addr, bus.dReadData, err, exp_sticky, exp_err_addr, exp_rd);
         end
         for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || access_err !== 1'b0) begin
               n_fail++; $display("FAIL random_hold%0d busy=%b err=%b exp busy=0 err=0", n, busy, access_err);
            end
         end
         end_access();
         $display("random %0d: rd=%b wr=%b addr=%h data=%h err=%b rdata=%h", n, rd, wr, a, d, err, bus.dReadData);
      end
   endtask

   task automatic test_reset_mid();
      bit err;
      logic [31:0] a = BASE + 32'd28;
      model_access(1'b0, 1'b1, a, 32'h5A5A_1234, err);
      start_access(1'b0, 1'b1, a, 32'h5A5A_1234);
      end_access();
      model_access(1'b1, 1'b0, a, 32'h0, err);
      start_access(1'b1, 1'b0, a, 32'h0);
      // Now in READ; assert reset with the read strobe still high.
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (bus.dReadData !== 32'h0 || busy !== 1'b0 || access_err !== 1'b0 ||
          err_sticky !== 1'b0 || err_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs rdata=%h busy=%b err=%b sticky=%b err_addr=%h exp all zero",
                  bus.dReadData, busy, access_err, err_sticky, err_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Held strobe counts as a new read after release.
      model_access(1'b1, 1'b0, a, 32'h0, err);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_replay busy=%b exp=1", busy); end
      n_checks++;
      if (bus.dReadData !== 32'h5A5A_1234) begin n_fail++; $display("FAIL reset_mid_mem_kept got=%h exp=5a5a1234", bus.dReadData); end
      end_access();
      $display("reset_mid: addr=%h readback=%h", a, bus.dReadData);
   endtask

`ifdef DMEM_STATS_EN
   task automatic test_stats();
      bit err;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         model_access(1'b1, 1'b0, BASE, 32'h0, err);
         start_access(1'b1, 1'b0, BASE, 32'h0);
         end_access();
      end
      for (int i = 0; i < 2; i++) begin
         model_access(1'b0, 1'b1, BASE + 32'd4, 32'(i), err);
         start_access(1'b0, 1'b1, BASE + 32'd4, 32'(i));
         end_access();
      end
      model_access(1'b1, 1'b0, BASE + 32'd1, 32'h0, err);
      start_access(1'b1, 1'b0, BASE + 32'd1, 32'h0);
      end_access();
      n_checks++;
      if (rd_count !== 16'd3 || wr_count !== 16'd2 || err_count !== 16'd1) begin
         n_fail++; $display("FAIL stats_counts rd=%0d wr=%0d err=%0d exp 3 2 1", rd_count, wr_count, err_count);
      end
      force dut.wr_cnt_reg = 16'hFFFE;
      @(negedge clk);
      release dut.wr_cnt_reg;
      for (int i = 0; i < 2; i++) begin
         model_access(1'b0, 1'b1, BASE + 32'd4, 32'h55, err);
         start_access(1'b0, 1'b1, BASE + 32'd4, 32'h55);
         end_access();
         n_checks++;
         if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate%0d got=%h exp=ffff", i, wr_count); end
      end
      $display("stats: rd=%0d wr=%h err=%0d", rd_count, wr_count, err_count);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_load();
      test_misaligned();
      test_range_edges();
      test_simultaneous();
      test_random();
      test_reset_mid();
`ifdef DMEM_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the multicycle RISC-V core's data port. It samples the core's `MemRead`/`MemWrite` strobes, `dAddress` and `dWriteData`, and services word accesses against an internal word-addressed RAM. Load data is returned on `dReadData` in time for the core's write-back state. Accesses that are out of range, misaligned or have conflicting strobes are rejected and reported. It sits between the core and the testbench/SoC, replacing a behavioural data memory.

## Interface
- `BASE_ADDR`, default 32'h1001_0000: byte address of word 0.
- `DEPTH_WORDS`, default 1024: number of 32-bit words, power of two, at least 2.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `MemRead` input, 1 bit: load strobe from the core (level).
- `MemWrite` input, 1 bit: store strobe from the core (level).
- `dAddress` input, 32 bits: byte address.
- `dWriteData` input, 32 bits: store data.
- `dReadData` output, 32 bits: registered load data.
- `busy` output, 1 bit: high while the FSM is not in IDLE.
- `access_err` output, 1 bit: one-cycle pulse on a rejected access.
- `err_sticky` output, 1 bit: set by any rejected access, cleared only by reset.
- `err_addr` output, 32 bits: `dAddress` of the most recent rejected access.

## Operation
- **Access detection:**
  - Registers `rd_q`/`wr_q` hold the previous-cycle strobes.
  - A new read is `MemRead & ~rd_q`; a new write is `MemWrite & ~wr_q`.
  - A strobe held for N cycles is exactly one access.
- **New accesses in IDLE only:** a rising strobe seen in any other state is dropped. Its `rd_q`/`wr_q` still update, so it is not replayed.
- **Address decode:**
  - `off = dAddress - BASE_ADDR` (32-bit unsigned).
  - Valid iff `off < 4*DEPTH_WORDS` and `dAddress[1:0] == 0`.
  - Word index is `off[log2(DEPTH_WORDS)+1:2]`.
- **FSM states:**
  - IDLE → READ on a new read with a valid address.
  - IDLE → WRITE on a new write with a valid address.
  - IDLE → ERROR on an invalid address, or on new read and new write in the same cycle.
  - READ, WRITE and ERROR each last one cycle, then return to IDLE.
- **Read:**
  - `dReadData` is loaded with `mem[idx]` on the IDLE→READ edge.
  - It holds that value until the next successful read.
- **Write:**
  - `mem[idx] <= dWriteData` on the IDLE→WRITE edge.
  - A read of the same word after this edge returns the new data.
- **Error:**
  - On the IDLE→ERROR edge: `err_addr <= dAddress`, `err_sticky <= 1`.
  - `access_err` is high for the ERROR cycle only.
  - Memory and `dReadData` are unchanged.
  - A simultaneous read+write is an error, not a prioritised access.

## Timing
- **Reset values:** `dReadData` = 0, `busy` = 0, `access_err` = 0, `err_sticky` = 0, `err_addr` = 0, state IDLE, `rd_q`/`wr_q` = 0.
- **No array reset:** RAM contents are not reset and survive `rst_n` assertion.
- **Read latency:** 1 cycle. A strobe sampled at edge k gives valid `dReadData` after edge k, i.e. before edge k+1.
- **Write latency:** the write is committed at edge k.
- **Back-to-back accesses:** minimum spacing is 2 cycles (IDLE, service state). The core's IF→ID→EX→MEM→WB sequencing always satisfies this.
- **Reset mid-operation:**
  - A write in progress either committed at its edge or did not start; no partial write exists.
  - The FSM returns to IDLE.
  - A strobe still high at reset release counts as a new access, because `rd_q`/`wr_q` reset to 0.
- **Address wrap-around:** `dAddress < BASE_ADDR` wraps `off` to a large value and is rejected.

## Configuration
- **`DMEM_STATS_EN` defined:**
  - Adds outputs `rd_count`, `wr_count` and `err_count`, 16 bits each.
  - Each counts completed READ, WRITE and ERROR states respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- **`DMEM_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Structure
- **Shared package `dmem_pkg`:**
  - FSM state encoding (IDLE, READ, WRITE, ERROR).
  - Default `BASE_ADDR`.
  - Counter width constant `DMEM_CNT_W` = 16.
- **Sub-module `dmem_ram`:**
  - Single-port synchronous RAM with `we`, `addr`, `wdata` and registered `rdata`.
  - `DEPTH_WORDS` deep.
  - Holds the array, so it can later be swapped for a technology macro.

## Test plan
- **Store then load:** `MemWrite` held 2 cycles at 32'h1001_0004 with 32'hCAFE_F00D. Then `MemRead` at the same address → exactly one write; `dReadData` = 32'hCAFE_F00D one cycle after the read strobe; `access_err` never high.
- **Misaligned load:** `MemRead` at 32'h1001_0002 → `access_err` pulse for 1 cycle; `err_sticky` = 1; `err_addr` = 32'h1001_0002; `dReadData` unchanged.
- **Address range edges:** `MemWrite` at BASE+4*DEPTH-4 succeeds. Then BASE+4*DEPTH → error. Then 32'h1000_FFFC → error through wrap-around.
- **Simultaneous strobes:** `MemRead` and `MemWrite` rise in the same cycle at a valid address → ERROR state; memory word unchanged, verified by a later read.
- **Reset mid-operation:** assert `rst_n` low during a READ state → all outputs at reset values, including `dReadData` = 0. A word written before reset still reads back its old value afterwards.
- **With `DMEM_STATS_EN`:** 3 reads, 2 writes, 1 error → `rd_count` = 3, `wr_count` = 2, `err_count` = 1. Preload `wr_count` to 16'hFFFF with forced writes, do one more write → `wr_count` stays at 16'hFFFF.
